// File: rtl/debounce_pkg.sv
// Shared types and constants for the signal debouncer: FSM state encoding
// and the smallest legal values of the debouncer parameters.
package debounce_pkg;

    // state[1] carries the output level whenever the FSM is in a STABLE state
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b11,
        PEND_LO   = 2'b10
    } deb_state_e;

    localparam int unsigned SYNC_STAGES_MIN     = 32'd2;
    localparam int unsigned DEBOUNCE_CYCLES_MIN = 32'd1;

    function automatic deb_state_e stable_of(input logic level);
        return level ? STABLE_HI : STABLE_LO;
    endfunction

    function automatic deb_state_e pend_toward(input logic level);
        return level ? PEND_HI : PEND_LO;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Plain multi-flop synchroniser for a single asynchronous bit; the chain
// has no logic between stages so every flop can sit in a resync cell.
module sync_ff_chain #(
    parameter int unsigned SYNC_STAGES = 32'd2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the chain, oldest sample at the top bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/signal_debouncer.sv
// Synchronises a bouncy asynchronous input and only passes a level change
// once it has been held for DEBOUNCE_CYCLES synchronised samples.
module signal_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 32'd2,
    parameter int unsigned DEBOUNCE_CYCLES = 32'd16,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic CLK_I,
    input  logic RST_ASYNC_NI,
    input  logic SIG_I,
    output logic SIG_O,
    output logic SIG_CHANGE_O,
    output logic GLITCH_O,
    output logic BUSY_O
);

    // Out-of-range parameters are pulled up to the smallest working value
    localparam int unsigned SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
    localparam int unsigned DEB_N  = (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) ? DEBOUNCE_CYCLES_MIN : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_WIDTH = $clog2(DEB_N + 32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEB_N - 32'd1);

    logic           sync_s;
    deb_state_e     state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic           sig_q;
    logic           change_q;
    logic           glitch_q;
    logic           busy_q;

    sync_ff_chain #(
        .SYNC_STAGES (SYNC_N),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clk_i  (CLK_I),
        .rst_ni (RST_ASYNC_NI),
        .d_i    (SIG_I),
        .q_o    (sync_s)
    );

    // Debounce FSM with stability counter and registered status outputs
    always_ff @(posedge CLK_I or negedge RST_ASYNC_NI) begin
        if (!RST_ASYNC_NI) begin
            state_q  <= stable_of(RESET_VALUE);
            cnt_q    <= '0;
            sig_q    <= RESET_VALUE;
            change_q <= 1'b0;
            glitch_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            change_q <= 1'b0;
            glitch_q <= 1'b0;
            case (state_q)
                STABLE_LO, STABLE_HI: begin
                    if (sync_s == sig_q) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                    end else if (DEB_N == 32'd1) begin
                        sig_q    <= sync_s;
                        change_q <= 1'b1;
                        state_q  <= stable_of(sync_s);
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        state_q <= pend_toward(sync_s);
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                PEND_HI, PEND_LO: begin
                    // A sample back at the old level aborts; this check wins over expiry
                    if (sync_s == sig_q) begin
                        state_q  <= stable_of(sig_q);
                        cnt_q    <= '0;
                        glitch_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        sig_q    <= sync_s;
                        change_q <= 1'b1;
                        state_q  <= stable_of(sync_s);
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q + CNT_ONE;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= stable_of(sig_q);
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SIG_O        = sig_q;
    assign SIG_CHANGE_O = change_q;
    assign GLITCH_O     = glitch_q;
    assign BUSY_O       = busy_q;

endmodule

// File: tb/tb_signal_debouncer.sv
// Bench for signal_debouncer: three parameterisations share one clock; a
// vector table drives the DEBOUNCE_CYCLES=4 instance, hand sequences cover latency and reset.
module tb_signal_debouncer;

    typedef struct {
        logic       sig;
        logic [3:0] exp;
    } vec_t;

    logic clk;
    logic rst16, rst4, rst1;
    logic sig16, sig4, sig1;
    logic [3:0] o16, o4, o1;
    int checks;
    int failures;
    logic [3:0] exp_q[$];
    vec_t vecs[38];

    signal_debouncer #(.SYNC_STAGES(32'd2), .DEBOUNCE_CYCLES(32'd16), .RESET_VALUE(1'b0)) u_dut16 (
        .CLK_I(clk), .RST_ASYNC_NI(rst16), .SIG_I(sig16),
        .SIG_O(o16[3]), .SIG_CHANGE_O(o16[2]), .GLITCH_O(o16[1]), .BUSY_O(o16[0]));

    signal_debouncer #(.SYNC_STAGES(32'd2), .DEBOUNCE_CYCLES(32'd4), .RESET_VALUE(1'b0)) u_dut4 (
        .CLK_I(clk), .RST_ASYNC_NI(rst4), .SIG_I(sig4),
        .SIG_O(o4[3]), .SIG_CHANGE_O(o4[2]), .GLITCH_O(o4[1]), .BUSY_O(o4[0]));

    signal_debouncer #(.SYNC_STAGES(32'd2), .DEBOUNCE_CYCLES(32'd1), .RESET_VALUE(1'b1)) u_dut1 (
        .CLK_I(clk), .RST_ASYNC_NI(rst1), .SIG_I(sig1),
        .SIG_O(o1[3]), .SIG_CHANGE_O(o1[2]), .GLITCH_O(o1[1]), .BUSY_O(o1[0]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={sig,chg,gl,busy}=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pick(input int sel);
        case (sel)
            16:      return o16;
            4:       return o4;
            default: return o1;
        endcase
    endfunction

    // Watch an instance for a bounded number of edges; report first edge with SIG_O==lvl and pulse counts
    task automatic run_until(input int sel, input logic lvl, input int max_edges,
                             output int edge_n, output int chg_n, output int gl_n, output int busy_n);
        logic [3:0] v;
        edge_n = 0; chg_n = 0; gl_n = 0; busy_n = 0;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clk);
            #1;
            v = pick(sel);
            if (v[3] == lvl && edge_n == 0) edge_n = i;
            if (v[2]) chg_n++;
            if (v[1]) gl_n++;
            if (v[0]) busy_n++;
        end
    endtask

    initial begin
        int e, c, g, b;
        logic [3:0] exp_v;
        checks = 0;
        failures = 0;

        // {SIG_I, expected {SIG_O, SIG_CHANGE_O, GLITCH_O, BUSY_O}} per cycle for DEBOUNCE_CYCLES=4
        vecs[0]  = '{1'b1, 4'b0000}; vecs[1]  = '{1'b1, 4'b0000}; vecs[2]  = '{1'b1, 4'b0001};
        vecs[3]  = '{1'b1, 4'b0001}; vecs[4]  = '{1'b1, 4'b0001}; vecs[5]  = '{1'b1, 4'b1100};
        vecs[6]  = '{1'b1, 4'b1000}; vecs[7]  = '{1'b1, 4'b1000}; vecs[8]  = '{1'b0, 4'b1000};
        vecs[9]  = '{1'b0, 4'b1000}; vecs[10] = '{1'b0, 4'b1001}; vecs[11] = '{1'b0, 4'b1001};
        vecs[12] = '{1'b0, 4'b1001}; vecs[13] = '{1'b0, 4'b0100}; vecs[14] = '{1'b0, 4'b0000};
        vecs[15] = '{1'b0, 4'b0000}; vecs[16] = '{1'b1, 4'b0000}; vecs[17] = '{1'b1, 4'b0000};
        vecs[18] = '{1'b0, 4'b0001}; vecs[19] = '{1'b0, 4'b0001}; vecs[20] = '{1'b0, 4'b0010};
        vecs[21] = '{1'b0, 4'b0000}; vecs[22] = '{1'b0, 4'b0000}; vecs[23] = '{1'b0, 4'b0000};
        vecs[24] = '{1'b1, 4'b0000}; vecs[25] = '{1'b0, 4'b0000}; vecs[26] = '{1'b1, 4'b0001};
        vecs[27] = '{1'b1, 4'b0010}; vecs[28] = '{1'b0, 4'b0001}; vecs[29] = '{1'b1, 4'b0001};
        vecs[30] = '{1'b1, 4'b0010}; vecs[31] = '{1'b1, 4'b0001}; vecs[32] = '{1'b1, 4'b0001};
        vecs[33] = '{1'b1, 4'b0001}; vecs[34] = '{1'b1, 4'b1100}; vecs[35] = '{1'b1, 4'b1000};
        vecs[36] = '{1'b1, 4'b1000}; vecs[37] = '{1'b1, 4'b1000};

        rst16 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
        sig16 = 1'b1; sig4 = 1'b0; sig1 = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("reset16_c%0d", i), o16, 4'b0000);
            check_vec($sformatf("reset1_c%0d", i), o1, 4'b1000);
        end
        @(negedge clk);
        rst16 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
        run_until(16, 1'b1, 24, e, c, g, b);
        check_int("dut16_rise_edge", e, 18);
        check_int("dut16_change_pulses", c, 1);
        check_int("dut16_glitch_pulses", g, 0);
        check_int("dut16_busy_cycles", b, 15);

        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            sig4 = vecs[i].sig;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            check_vec($sformatf("vec%0d", i), o4, exp_v);
        end

        // Async reset in the middle of a pending rise must restart the hold from scratch
        @(negedge clk);
        rst4 = 1'b0; sig4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        repeat (3) @(negedge clk);
        sig4 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_vec("dut4_pend_cnt2", o4, 4'b0001);
        #2;
        rst4 = 1'b0;
        #1;
        check_vec("dut4_async_clear", o4, 4'b0000);
        @(negedge clk);
        rst4 = 1'b1;
        run_until(4, 1'b1, 10, e, c, g, b);
        check_int("dut4_restart_rise_edge", e, 6);
        check_int("dut4_restart_change", c, 1);
        check_int("dut4_restart_glitch", g, 0);
        check_int("dut4_restart_busy", b, 3);

        @(negedge clk);
        check_vec("dut1_idle_high", o1, 4'b1000);
        sig1 = 1'b0;
        run_until(1, 1'b0, 8, e, c, g, b);
        check_int("dut1_fall_edge", e, 3);
        check_int("dut1_change", c, 1);
        check_int("dut1_busy", b, 0);
        check_int("dut1_glitch", g, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signal_debouncer.md
Name: signal_debouncer

Overview:
- Upstream conditioning stage for the edge detector blocks.
- Takes a raw asynchronous, bouncy input (button, external strobe, comparator output) and synchronises it into CLK_I.
- Passes a level change only after it has been held stable for a programmable number of cycles.
- SIG_O connects directly to an edge detector's SIG_I; status pulses report accepted changes and rejected glitches.

Parameters:
- SYNC_STAGES, 2, synchroniser depth in flops; legal values >= 2.
- DEBOUNCE_CYCLES, 16, consecutive synchronised samples that must differ from SIG_O before SIG_O changes; legal values >= 1.
- RESET_VALUE, 1'b0, reset level of the synchroniser flops and SIG_O.
- CNT_WIDTH (localparam), $clog2(DEBOUNCE_CYCLES+1), stability counter width.

Ports:
- CLK_I  input  1  single system clock, rising-edge.
- RST_ASYNC_NI  input  1  reset; asynchronous and active-low; one clock, no other clock domains.
- SIG_I  input  1  raw asynchronous input.
- SIG_O  output  1  debounced, synchronous level.
- SIG_CHANGE_O  output  1  one-cycle pulse in the first cycle SIG_O shows a new value.
- GLITCH_O  output  1  one-cycle pulse when a pending change is aborted.
- BUSY_O  output  1  high while a change is pending (FSM in a PEND state).

Behaviour:
- Reset (RST_ASYNC_NI=0):
  - Asynchronously clears all state immediately, including mid-pend.
  - Synchroniser flops = RESET_VALUE; SIG_O = RESET_VALUE.
  - SIG_CHANGE_O = GLITCH_O = BUSY_O = 0; counter = 0.
  - FSM = STABLE_LO if RESET_VALUE=0, else STABLE_HI.
- Release: deassertion takes effect at the next rising edge. No output pulses are generated by reset or its release.
- Synchroniser: SYNC_STAGES-flop chain; its last stage is s. No logic between chain flops.
- FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO. SIG_O is a register that tracks the STABLE level.
- In STABLE_x:
  - s == SIG_O: stay.
  - s != SIG_O and DEBOUNCE_CYCLES == 1: flip SIG_O, pulse SIG_CHANGE_O, go to the opposite STABLE state.
  - s != SIG_O otherwise: go to the PEND state, counter = 1.
- In PEND_x:
  - s == SIG_O: return to STABLE, counter = 0, GLITCH_O = 1 next cycle.
  - s != SIG_O and counter == DEBOUNCE_CYCLES-1: flip SIG_O, SIG_CHANGE_O = 1 next cycle, go to the opposite STABLE state, counter = 0.
  - Otherwise: counter + 1.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
- Latency: a clean SIG_I step produces SIG_O change and SIG_CHANGE_O after exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
- Pulses out of a PEND state cannot fire in consecutive cycles: a fresh PEND needs DEBOUNCE_CYCLES >= 2 to complete.
- BUSY_O = 1 exactly in PEND_HI / PEND_LO.
- SIG_CHANGE_O and GLITCH_O are mutually exclusive in any cycle.
- All outputs are registered; there is no combinational path from SIG_I to any output.
- Simultaneous abort and expiry cannot occur: the comparison is a single sample per cycle, so abort has priority by construction.
- A glitch shorter than DEBOUNCE_CYCLES synchronised samples never reaches SIG_O.

Decomposition:
- Shared package debounce_pkg:
  - 2-bit state encoding constants: STABLE_LO=2'b00, PEND_HI=2'b01, STABLE_HI=2'b11, PEND_LO=2'b10.
  - Encoding chosen so that state[1] equals the SIG_O level in STABLE states.
  - Legal-range check constants for SYNC_STAGES and DEBOUNCE_CYCLES.
- One sub-module: sync_ff_chain, parameters SYNC_STAGES and RESET_VALUE; async active-low reset; reusable by other blocks.
- FSM, counter and output registers stay in signal_debouncer.

Test Plan:
- Defaults (SYNC_STAGES=2, DEBOUNCE_CYCLES=16), reset held 3 cycles, SIG_I=1 during reset -> all outputs held at 0 throughout; after release SIG_O rises exactly 18 edges later with one SIG_CHANGE_O pulse.
- DEBOUNCE_CYCLES=4: SIG_I 0->1 step held -> BUSY_O high for 3 cycles, SIG_O=1 and SIG_CHANGE_O=1 at edge 6 after the step, GLITCH_O never asserts.
- DEBOUNCE_CYCLES=4: SIG_I high for 2 cycles then low -> BUSY_O pulses, exactly one GLITCH_O pulse, SIG_O stays 0, no SIG_CHANGE_O.
- DEBOUNCE_CYCLES=4: bounce pattern 1,0,1,1,0,1,1,1,1 (one value per cycle) then hold 1 -> two GLITCH_O pulses, then SIG_O=1 only after 4 consecutive synchronised 1s.
- DEBOUNCE_CYCLES=4: RST_ASYNC_NI pulsed low between clock edges while in PEND_HI (counter=2) -> outputs clear immediately without waiting for an edge; after release the hold must restart and takes the full 6 edges.
- DEBOUNCE_CYCLES=1, RESET_VALUE=1: SIG_I 1->0 -> SIG_O falls exactly 3 edges later, BUSY_O never asserts.
